// File: rtl/memory_responder.sv
// Word RAM behind a posted-write buffer, with a 1-cycle read FSM (IDLE/RESP); `MEMORY_RESPONDER_FWD_EN enables store-to-load forwarding.
// Latency: read valid 1 cycle after the service cycle, at most one read per 2 cycles; buffered writes drain in any cycle without a read service.
// Backpressure: mem_wr_ready_o drops when the buffer is full; writes presented then are dropped and set a sticky overflow flag.
module memory_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WB_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_rd_req_i,
    input  logic [31:0] mem_rd_addr_i,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_rd_valid_o,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_wr_data_i,
    input  logic        mem_wr_enable_i,
    output logic        mem_wr_ready_o,
    output logic        mem_wr_overflow_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam logic [PW:0] WB_FULL = (PW+1)'(WB_DEPTH);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   dat;
    } wb_entry_t;

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          ovf_q, ovf_d;
    wb_entry_t     wb_q [WB_DEPTH];
    logic [31:0]   ram [DEPTH_WORDS];

    logic [AW-1:0] rd_idx;
    wb_entry_t     push_entry, head_entry;
    logic          rd_permit, service, push, drain, wr_ready;
    logic [31:0]   ram_rd_dat, rd_result;
    logic          unused_addr_bits;

    assign rd_idx     = mem_rd_addr_i[AW+1:2];
    assign push_entry = {mem_wr_addr_i[AW+1:2], mem_wr_data_i};
    assign head_entry = wb_q[rd_ptr_q];
    assign ram_rd_dat = ram[rd_idx];
    assign unused_addr_bits = ^{mem_rd_addr_i[31:AW+2], mem_rd_addr_i[1:0],
                                mem_wr_addr_i[31:AW+2], mem_wr_addr_i[1:0]};

`ifdef MEMORY_RESPONDER_FWD_EN
    logic          fwd_hit;
    logic [31:0]   fwd_dat;
    logic [PW-1:0] slot;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        slot    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (wb_q[slot].idx == rd_idx)) begin
                fwd_hit = 1'b1;
                fwd_dat = wb_q[slot].dat;
            end
        end
    end

    assign rd_permit = 1'b1;
    assign rd_result = fwd_hit ? fwd_dat : ram_rd_dat;
`else
    assign rd_permit = (count_q == '0);
    assign rd_result = ram_rd_dat;
`endif

    // The single RAM port goes to a read service first; drain only takes idle slots.
    assign wr_ready = (count_q != WB_FULL);
    assign service  = (state_q == IDLE) && mem_rd_req_i && rd_permit;
    assign push     = mem_wr_enable_i && wr_ready;
    assign drain    = (count_q != '0) && !service;

    always_comb begin
        wr_ptr_d  = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !drain) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!push && drain) begin
            count_d = count_q - (PW+1)'(1);
        end
        ovf_d     = ovf_q | (mem_wr_enable_i & ~wr_ready);
        rd_data_d = service ? rd_result : rd_data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (service) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_valid_o    = (state_q == RESP);
        mem_rd_data_o     = rd_data_q;
        mem_wr_ready_o    = wr_ready;
        mem_wr_overflow_o = ovf_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage only: entry validity lives in the pointers/count, RAM keeps contents across reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            wb_q[wr_ptr_q] <= push_entry;
        end
        if (drain) begin
            ram[head_entry.idx] <= head_entry.dat;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: scoreboard of expected read data, one task per scenario.
`timescale 1ns/1ps
module tb_memory_responder;
    localparam int DEPTH_WORDS = 4096;
    localparam int WB_DEPTH    = 4;
`ifdef MEMORY_RESPONDER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i;
    logic        reset_ni;
    logic        mem_rd_req_i;
    logic [31:0] mem_rd_addr_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_rd_valid_o;
    logic [31:0] mem_wr_addr_i;
    logic [31:0] mem_wr_data_i;
    logic        mem_wr_enable_i;
    logic        mem_wr_ready_o;
    logic        mem_wr_overflow_o;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    memory_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .mem_rd_req_i(mem_rd_req_i), .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_data_o(mem_rd_data_o), .mem_rd_valid_o(mem_rd_valid_o),
        .mem_wr_addr_i(mem_wr_addr_i), .mem_wr_data_i(mem_wr_data_i),
        .mem_wr_enable_i(mem_wr_enable_i), .mem_wr_ready_o(mem_wr_ready_o),
        .mem_wr_overflow_o(mem_wr_overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH_WORDS));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write1(input logic [31:0] a, input logic [31:0] d);
        mem_wr_enable_i = 1'b1;
        mem_wr_addr_i   = a;
        mem_wr_data_i   = d;
        model[widx(a)]  = d;
        tick();
        mem_wr_enable_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] dat, output bit got);
        mem_rd_req_i  = 1'b1;
        mem_rd_addr_i = a;
        lat = 0;
        got = 1'b0;
        dat = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (mem_rd_valid_o) begin
                got = 1'b1;
                dat = mem_rd_data_o;
            end else begin
                lat++;
            end
        end
        @(posedge clk_i);
        #1;
        mem_rd_req_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b1;
        mem_rd_req_i = 1'b0; mem_rd_addr_i = '0;
        mem_wr_enable_i = 1'b0; mem_wr_addr_i = '0; mem_wr_data_i = '0;
        #2 reset_ni = 1'b0;
        #1;
        n_tests++; if (mem_rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_rd_valid_o); end
        n_tests++; if (mem_rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mem_rd_data_o); end
        n_tests++; if (mem_wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", mem_wr_ready_o); end
        n_tests++; if (mem_wr_overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", mem_wr_overflow_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; bit got; logic [31:0] d, e;
        write1(32'h100, 32'h1122_3344);
        idle(2);
        exp_q.push_back(32'h1122_3344);
        do_read(32'h100, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got) begin n_fail++; $display("FAIL basic_valid: no valid within bound"); end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL basic_latency: got %0d want 1", lat); end
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL basic_data: got %h want %h", d, e); end
    endtask

    task automatic test_fwd();
        int lat; bit got; logic [31:0] d, e;
        int want_lat;
        want_lat = FWD ? 1 : 2;
        mem_wr_enable_i = 1'b1; mem_wr_addr_i = 32'h40;
        mem_wr_data_i = 32'hA; model[widx(32'h40)] = 32'hA; tick();
        mem_wr_data_i = 32'hB; model[widx(32'h40)] = 32'hB; tick();
        mem_wr_enable_i = 1'b0;
        exp_q.push_back(32'hB);
        do_read(32'h40, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got) begin n_fail++; $display("FAIL fwd_valid: no valid within bound"); end
        n_tests++; if (lat != want_lat) begin n_fail++; $display("FAIL fwd_latency: got %0d want %0d", lat, want_lat); end
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL fwd_data: got %h want %h", d, e); end
    endtask

    task automatic test_hold();
        localparam logic [9:0] HOLD_PAT = 10'b10_1010_1010;
        logic [9:0]  pat;
        logic [31:0] e;
        idle(2);
        for (int i = 0; i < 5; i++) exp_q.push_back(model[widx(32'h100)]);
        mem_rd_req_i = 1'b1; mem_rd_addr_i = 32'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            pat[c] = mem_rd_valid_o;
            if (mem_rd_valid_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL hold_unexpected_valid: cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_rd_data_o !== e) begin n_fail++; $display("FAIL hold_data: got %h want %h", mem_rd_data_o, e); end
                end
            end
        end
        tick();
        mem_rd_req_i = 1'b0;
        n_tests++; if (pat !== HOLD_PAT) begin n_fail++; $display("FAIL hold_pattern: got %b want %b", pat, HOLD_PAT); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_count: %0d responses missing", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_overflow();
        logic [7:0]  exp_rdy, rdy_pat;
        logic [31:0] e, d;
        int lat; bit got; int nv;
        exp_rdy = FWD ? 8'h7F : 8'hFF;
        nv = FWD ? 4 : 1;
        idle(2);
        for (int i = 0; i < nv; i++) exp_q.push_back(model[widx(32'h100)]);
        mem_rd_req_i = 1'b1; mem_rd_addr_i = 32'h100;
        for (int c = 0; c < 8; c++) begin
            mem_wr_enable_i = 1'b1;
            mem_wr_addr_i   = 32'h200 + 32'(c * 4);
            mem_wr_data_i   = 32'hC0DE_0000 + 32'(c);
            if (exp_rdy[c]) model[widx(mem_wr_addr_i)] = mem_wr_data_i;
            rdy_pat[c] = mem_wr_ready_o;
            @(negedge clk_i);
            if (mem_rd_valid_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL ovf_unexpected_valid: cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_rd_data_o !== e) begin n_fail++; $display("FAIL ovf_rd_data: got %h want %h", mem_rd_data_o, e); end
                end
            end
            tick();
        end
        mem_wr_enable_i = 1'b0;
        mem_rd_req_i    = 1'b0;
        n_tests++; if (rdy_pat !== exp_rdy) begin n_fail++; $display("FAIL ovf_ready_pattern: got %b want %b", rdy_pat, exp_rdy); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_rd_count: %0d responses missing", exp_q.size()); exp_q.delete(); end
        idle(6);
        n_tests++; if (mem_wr_overflow_o !== FWD) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", mem_wr_overflow_o, FWD); end
        exp_q.push_back(32'hC0DE_0006);
        do_read(32'h218, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got || d !== e) begin n_fail++; $display("FAIL ovf_readback: got %h (valid %b) want %h", d, got, e); end
    endtask

    task automatic test_wrap();
        int lat; bit got; logic [31:0] d, e;
        write1(32'h4, 32'hAAAA_5555);
        write1(32'h4 + 32'(DEPTH_WORDS * 4), 32'h5555_AAAA);
        idle(3);
        exp_q.push_back(32'h5555_AAAA);
        do_read(32'h4, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got || d !== e) begin n_fail++; $display("FAIL wrap_data: got %h (valid %b) want %h", d, got, e); end
    endtask

    task automatic test_reset_resp();
        int lat; bit got; int nv; int rr_n;
        logic [31:0] d, e;
        write1(32'h300, 32'h1111_0300);
        write1(32'h304, 32'h2222_0304);
        idle(3);
        rr_n = FWD ? 3 : 1;
        if (FWD) begin
            exp_q.push_back(model[widx(32'h100)]);
            model[widx(32'h308)] = 32'h9000_0000;
        end
        mem_rd_req_i = 1'b1; mem_rd_addr_i = 32'h100;
        for (int c = 0; c < rr_n; c++) begin
            mem_wr_enable_i = 1'b1;
            mem_wr_addr_i   = !FWD ? 32'h300 : (c == 0) ? 32'h308 : (c == 1) ? 32'h300 : 32'h304;
            mem_wr_data_i   = 32'h9000_0000 + 32'(c);
            @(negedge clk_i);
            if (mem_rd_valid_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_unexpected_valid: cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_rd_data_o !== e) begin n_fail++; $display("FAIL rr_rd_data: got %h want %h", mem_rd_data_o, e); end
                end
            end
            tick();
        end
        mem_wr_enable_i = 1'b0;
        n_tests++; if (mem_rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_in_resp: got %b want 1", mem_rd_valid_o); end
        n_tests++; if (mem_wr_overflow_o !== FWD) begin n_fail++; $display("FAIL rr_ovf_before: got %b want %b", mem_wr_overflow_o, FWD); end
        reset_ni = 1'b0;
        #1;
        mem_rd_req_i = 1'b0;
        n_tests++; if (mem_rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_valid: got %b want 0", mem_rd_valid_o); end
        n_tests++; if (mem_rd_data_o !== 32'h0) begin n_fail++; $display("FAIL rr_data: got %h want 0", mem_rd_data_o); end
        n_tests++; if (mem_wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rr_ready: got %b want 1", mem_wr_ready_o); end
        n_tests++; if (mem_wr_overflow_o !== 1'b0) begin n_fail++; $display("FAIL rr_ovf: got %b want 0", mem_wr_overflow_o); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (mem_rd_valid_o) nv++;
        end
        tick();
        n_tests++; if (nv != 0) begin n_fail++; $display("FAIL rr_stale_valid: got %0d pulses want 0", nv); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_rd_count: %0d responses missing", exp_q.size()); exp_q.delete(); end
        exp_q.push_back(32'h1111_0300);
        exp_q.push_back(32'h2222_0304);
        do_read(32'h300, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got || d !== e) begin n_fail++; $display("FAIL rr_prior_0x300: got %h (valid %b) want %h", d, got, e); end
        do_read(32'h304, lat, d, got);
        e = exp_q.pop_front();
        n_tests++; if (!got || d !== e) begin n_fail++; $display("FAIL rr_prior_0x304: got %h (valid %b) want %h", d, got, e); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_fwd();
        test_hold();
        test_overflow();
        test_wrap();
        test_reset_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
